// File: rtl/ps_seizure_detector.sv
// Seizure tag generator over an adaptive-baseline feature stream; 1-cycle latency, no backpressure.
// Define PS_DET_HYST_EN to exit the alarm at half the trigger threshold instead of at the threshold.
module ps_seizure_detector #(
    parameter int IN_WIDTH   = 40,
    parameter int BASE_SHIFT = 4,
    parameter int K_SHIFT    = 2,
    parameter int WARMUP     = 64,
    parameter int TRIG_COUNT = 4,
    parameter int HOLD_COUNT = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [IN_WIDTH-1:0] din,
    input  logic                din_valid,
    output logic                tag,
    output logic                tag_valid,
    output logic                onset,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        ST_WARMUP  = 3'd0,
        ST_MONITOR = 3'd1,
        ST_ALARM   = 3'd2,
        ST_HOLDOFF = 3'd3
    } state_t;

    localparam int TW  = IN_WIDTH + K_SHIFT;
    localparam int M1  = (WARMUP > TRIG_COUNT) ? WARMUP : TRIG_COUNT;
    localparam int M2  = (M1 > HOLD_COUNT) ? M1 : HOLD_COUNT;
    localparam int CW  = $clog2(M2 + 1) + 1;

    state_t                r_state, w_state_nxt;
    logic [IN_WIDTH-1:0]   r_base, w_base_nxt;
    logic [CW-1:0]         r_warm, w_warm_nxt;
    logic [CW-1:0]         r_run, w_run_nxt;
    logic [CW-1:0]         r_exit, w_exit_nxt;
    logic [CW-1:0]         r_hold, w_hold_nxt;
    logic                  r_first, w_first_nxt;
    logic                  r_tag, w_tag_nxt;
    logic                  r_tag_vld, w_tag_vld_nxt;
    logic                  r_onset, w_onset_nxt;

    logic [IN_WIDTH-2:0]   w_x;
    logic signed [IN_WIDTH:0] w_diff, w_step;
    logic [IN_WIDTH-1:0]   w_base_upd, w_base_filt;
    logic [TW-1:0]         w_xe, w_trig, w_exit_thr;
    logic                  w_above, w_below_exit, w_accept;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == '1) ? c : c + CW'(1);
    endfunction

    assign w_accept    = en && din_valid;
    assign w_x         = din[IN_WIDTH-1] ? '0 : din[IN_WIDTH-2:0];
    assign w_diff      = $signed({2'b00, w_x}) - $signed({1'b0, r_base});
    assign w_step      = w_diff >>> BASE_SHIFT;
    assign w_base_upd  = IN_WIDTH'($unsigned(w_step) + {1'b0, r_base});
    assign w_base_filt = r_first ? {1'b0, w_x} : w_base_upd;

    assign w_xe        = {{(K_SHIFT+1){1'b0}}, w_x};
    assign w_trig      = {{K_SHIFT{1'b0}}, r_base} << K_SHIFT;
`ifdef PS_DET_HYST_EN
    assign w_exit_thr  = {{K_SHIFT{1'b0}}, r_base} << (K_SHIFT - 1);
`else
    assign w_exit_thr  = w_trig;
`endif
    assign w_above      = w_xe > w_trig;
    assign w_below_exit = w_xe <= w_exit_thr;

    always_comb begin
        w_state_nxt   = r_state;
        w_base_nxt    = r_base;
        w_warm_nxt    = r_warm;
        w_run_nxt     = r_run;
        w_exit_nxt    = r_exit;
        w_hold_nxt    = r_hold;
        w_first_nxt   = r_first;
        w_tag_nxt     = r_tag;
        w_tag_vld_nxt = 1'b0;
        w_onset_nxt   = 1'b0;
        if (w_accept) begin
            w_tag_vld_nxt = 1'b1;
            w_first_nxt   = 1'b0;
            case (r_state)
                ST_WARMUP: begin
                    w_tag_nxt  = 1'b0;
                    w_base_nxt = w_base_filt;
                    w_warm_nxt = sat_inc(r_warm);
                    if (sat_inc(r_warm) >= CW'(WARMUP)) begin
                        w_state_nxt = ST_MONITOR;
                        w_run_nxt   = '0;
                    end
                end
                ST_MONITOR: begin
                    w_tag_nxt = 1'b0;
                    if (w_above) begin
                        w_run_nxt = sat_inc(r_run);
                        if (sat_inc(r_run) >= CW'(TRIG_COUNT)) begin
                            w_state_nxt = ST_ALARM;
                            w_tag_nxt   = 1'b1;
                            w_onset_nxt = 1'b1;
                            w_exit_nxt  = '0;
                        end
                    end else begin
                        w_run_nxt  = '0;
                        w_base_nxt = w_base_filt;
                    end
                end
                ST_ALARM: begin
                    w_tag_nxt = 1'b1;
                    if (w_below_exit) begin
                        w_exit_nxt = sat_inc(r_exit);
                        if (sat_inc(r_exit) >= CW'(TRIG_COUNT)) begin
                            w_tag_nxt  = 1'b0;
                            w_hold_nxt = '0;
                            w_run_nxt  = '0;
                            // A zero hold-off skips the HOLDOFF state entirely
                            w_state_nxt = (HOLD_COUNT == 0) ? ST_MONITOR : ST_HOLDOFF;
                        end
                    end else begin
                        w_exit_nxt = '0;
                    end
                end
                ST_HOLDOFF: begin
                    w_tag_nxt  = 1'b0;
                    w_hold_nxt = sat_inc(r_hold);
                    if (sat_inc(r_hold) >= CW'(HOLD_COUNT)) begin
                        w_state_nxt = ST_MONITOR;
                        w_run_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_WARMUP;
                    w_tag_nxt   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_WARMUP;
            r_base    <= '0;
            r_warm    <= '0;
            r_run     <= '0;
            r_exit    <= '0;
            r_hold    <= '0;
            r_first   <= 1'b1;
            r_tag     <= 1'b0;
            r_tag_vld <= 1'b0;
            r_onset   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_base    <= w_base_nxt;
            r_warm    <= w_warm_nxt;
            r_run     <= w_run_nxt;
            r_exit    <= w_exit_nxt;
            r_hold    <= w_hold_nxt;
            r_first   <= w_first_nxt;
            r_tag     <= w_tag_nxt;
            r_tag_vld <= w_tag_vld_nxt;
            r_onset   <= w_onset_nxt;
        end
    end

    assign tag       = r_tag;
    assign tag_valid = r_tag_vld;
    assign onset     = r_onset;
    assign state     = r_state;

endmodule

// File: tb/tb_ps_seizure_detector.sv
// Bench for ps_seizure_detector: directed scenarios then random traffic against an arithmetic model.
module tb_ps_seizure_detector;

    localparam int IN_WIDTH   = 40;
    localparam int BASE_SHIFT = 2;
    localparam int K_SHIFT    = 2;
    localparam int WARMUP     = 4;
    localparam int TRIG_COUNT = 3;
    localparam int HOLD_COUNT = 5;
`ifdef PS_DET_HYST_EN
    localparam bit HYST = 1'b1;
`else
    localparam bit HYST = 1'b0;
`endif
    localparam longint XMAX = (longint'(1) <<< (IN_WIDTH - 1)) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en = 1'b0;
    logic [IN_WIDTH-1:0] din = '0;
    logic                din_valid = 1'b0;
    logic                tag, tag_valid, onset;
    logic [2:0]          state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: modes 0..3 follow the documented state numbering
    longint m_b;
    int     m_st, m_warm, m_run, m_exit, m_hold;
    bit     m_first, m_tag, m_tv, m_on;

    ps_seizure_detector #(
        .IN_WIDTH(IN_WIDTH), .BASE_SHIFT(BASE_SHIFT), .K_SHIFT(K_SHIFT),
        .WARMUP(WARMUP), .TRIG_COUNT(TRIG_COUNT), .HOLD_COUNT(HOLD_COUNT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
        .tag(tag), .tag_valid(tag_valid), .onset(onset), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_base(input longint x);
        if (m_first) m_b = x;
        else         m_b = m_b + ((x - m_b) >>> BASE_SHIFT);
    endtask

    task automatic model_step(input logic r, input logic e, input logic v, input longint d);
        longint x, t, ex;
        if (r) begin
            m_b = 0; m_st = 0; m_warm = 0; m_run = 0; m_exit = 0; m_hold = 0;
            m_first = 1; m_tag = 0; m_tv = 0; m_on = 0;
            return;
        end
        m_tv = 0;
        m_on = 0;
        if (!(e && v)) return;
        x  = (d < 0) ? 0 : d;
        t  = m_b * 4;
        ex = HYST ? m_b * 2 : t;
        m_tv = 1;
        case (m_st)
            0: begin
                model_base(x);
                m_warm++;
                if (m_warm >= WARMUP) m_st = 1;
            end
            1: begin
                if (x > t) begin
                    m_run++;
                    if (m_run >= TRIG_COUNT) begin
                        m_st = 2; m_tag = 1; m_on = 1; m_exit = 0;
                    end
                end else begin
                    m_run = 0;
                    model_base(x);
                end
            end
            2: begin
                if (x <= ex) begin
                    m_exit++;
                    if (m_exit >= TRIG_COUNT) begin
                        m_tag = 0; m_hold = 0; m_run = 0;
                        m_st = (HOLD_COUNT == 0) ? 1 : 3;
                    end
                end else begin
                    m_exit = 0;
                end
            end
            default: begin
                m_hold++;
                if (m_hold >= HOLD_COUNT) begin
                    m_st = 1; m_run = 0;
                end
            end
        endcase
        m_first = 0;
    endtask

    task automatic step(input logic r, input logic e, input logic v, input longint d);
        rst = r; en = e; din_valid = v; din = d[IN_WIDTH-1:0];
        @(posedge clk);
        model_step(r, e, v, d);
        #1;
        chk("tag",       64'(tag),       64'(m_tag));
        chk("tag_valid", 64'(tag_valid), 64'(m_tv));
        chk("onset",     64'(onset),     64'(m_on));
        chk("state",     64'(state),     64'(m_st));
        chk("base",      64'(dut.r_base), 64'(m_b));
    endtask

    task automatic feed(input int n, input longint d);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, d);
    endtask

    task automatic reset_and_warm();
        step(1'b1, 1'b1, 1'b1, 100);
        feed(WARMUP, 100);
        chk("warm_base", 64'(dut.r_base), 64'd100);
        chk("warm_state", 64'(state), 64'd1);
    endtask

    initial begin
        longint d;
        logic   r, e, v;

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 100);
            chk("rst_tag_valid", 64'(tag_valid), 64'd0);
        end
        feed(1, 100);
        chk("first_tag_valid", 64'(tag_valid), 64'd1);
        feed(WARMUP - 1, 100);
        chk("warm_state", 64'(state), 64'd1);

        feed(2, 401);
        chk("no_onset_yet", 64'(onset), 64'd0);
        feed(1, 401);
        chk("onset", 64'(onset), 64'd1);
        chk("alarm_state", 64'(state), 64'd2);

        if (HYST) begin
            feed(5, 250);
            chk("hyst_stay", 64'(state), 64'd2);
            feed(3, 200);
        end else begin
            feed(3, 399);
        end
        chk("holdoff_state", 64'(state), 64'd3);
        chk("holdoff_tag", 64'(tag), 64'd0);
        feed(HOLD_COUNT, 1000);
        chk("hold_done_state", 64'(state), 64'd1);
        chk("hold_base", 64'(dut.r_base), 64'd100);

        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 10000);
        chk("gate_state", 64'(state), 64'd1);
        chk("gate_base", 64'(dut.r_base), 64'd100);
        feed(TRIG_COUNT, 401);
        chk("reenable_alarm", 64'(state), 64'd2);

        step(1'b1, 1'b1, 1'b1, 401);
        chk("midrst_tag", 64'(tag), 64'd0);
        chk("midrst_state", 64'(state), 64'd0);
        chk("midrst_base", 64'(dut.r_base), 64'd0);
        feed(1, -50);
        chk("clamp_b0", 64'(dut.r_base), 64'd0);
        feed(1, 100);
        chk("clamp_b1", 64'(dut.r_base), 64'd25);
        feed(1, 100);
        chk("clamp_b2", 64'(dut.r_base), 64'd43);
        feed(1, 100);
        chk("clamp_b3", 64'(dut.r_base), 64'd57);
        chk("clamp_state", 64'(state), 64'd1);

        reset_and_warm();
        feed(10, 400);
        chk("eq_no_trig", 64'(state), 64'd1);

        reset_and_warm();
        feed(2, 401);
        feed(1, 100);
        feed(1, 401);
        chk("run_reset", 64'(state), 64'd1);

        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 5) != 0);
            case ($urandom_range(0, 4))
                0:       d = longint'($urandom_range(0, 300));
                1:       d = m_b * 4 + longint'($urandom_range(0, 2)) - 1;
                2:       d = -longint'($urandom_range(1, 1000));
                3:       d = m_b * 2 + longint'($urandom_range(0, 2)) - 1;
                default: d = m_b * 4 + longint'($urandom_range(1, 1000));
            endcase
            if (d > XMAX) d = XMAX;
            step(r, e, v, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
